// File: rtl/mjs_pkg.sv
// Shared types and helpers for the multiplier job sequencer.
// Holds the FSM state enum, default widths and a pointer-width helper.
package mjs_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_RES_W = 2 * DEF_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/mjs_operand_fifo.sv
// Synchronous operand FIFO with wrap-bit pointers; head read combinationally.
// Ports: clk, rst (sync, active high), push/din, pop/dout, full, empty.
module mjs_operand_fifo
    import mjs_pkg::*;
#(
    parameter int W     = DEF_RES_W,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_job_sequencer.sv
// Feeds buffered operand pairs to the leading-one multiplier one job at a
// time, answers zero operands locally and streams products out.
// Ports: clk/rst; in_valid/in_ready/in_a/in_b operand stream;
// mul_start/mul_a/mul_b/mul_done/mul_result/mul_rst multiplier side;
// out_valid/out_ready/out_result/out_err result stream; busy status.
// Optional watchdog on the multiplier wait: define MJS_TIMEOUT_EN.
module mult_job_sequencer
    import mjs_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic               mul_done,
    input  logic [2*WIDTH-1:0] mul_result,
    output logic               mul_rst,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_result,
    output logic               out_err,
    output logic               busy
);

    state_t state;
    state_t state_nxt;

    logic [2*WIDTH-1:0] head;
    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic zero_op;
    logic done_hit;
    logic expire;

    mjs_operand_fifo #(
        .W     (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .din   ({in_a, in_b}),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The multiplier's leading-one search hangs on zero, so skip it.
    assign zero_op = (head[2*WIDTH-1:WIDTH] == '0) ||
                     (head[WIDTH-1:0] == '0);

    assign in_ready  = !fifo_full;
    assign done_hit  = (state == WAIT) && mul_done;
    assign mul_start = (state == ISSUE);
    assign out_valid = (state == OUT);
    assign busy      = !fifo_empty || (state != IDLE);
    assign mul_rst   = rst || expire;

`ifdef MJS_TIMEOUT_EN
    localparam int CNT_W = clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    always_ff @(posedge clk) begin
        if (rst || state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Fires in the last allowed WAIT cycle; a same-cycle done wins.
    assign expire = (state == WAIT) && !mul_done &&
                    (wait_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (pop) begin
            err_q <= 1'b0;
        end else if (expire) begin
            err_q <= 1'b1;
        end
    end

    assign out_err = err_q;
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = 32'(TIMEOUT_CYC);
    assign expire         = 1'b0;
    assign out_err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = zero_op ? OUT : ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (mul_done || expire) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a      <= '0;
            mul_b      <= '0;
            out_result <= '0;
        end else begin
            if (pop) begin
                mul_a <= head[2*WIDTH-1:WIDTH];
                mul_b <= head[WIDTH-1:0];
                if (zero_op) begin
                    out_result <= '0;
                end
            end
            if (done_hit) begin
                out_result <= mul_result;
            end else if (expire) begin
                out_result <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Self-checking bench for mult_job_sequencer with a behavioural multiplier.
// Expected {err, product} pairs are queued at push and popped at output.
module tb_mult_job_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        mul_start;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic        mul_done = 1'b0;
    logic [31:0] mul_result = '0;
    logic        mul_rst;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_err;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int out_count = 0;

    logic [32:0] exp_q[$];
    logic [32:0] sb_exp;

    int   mdl_lat = 20;
    int   mdl_cnt = 0;
    logic mdl_hang = 1'b0;
    logic mdl_busy = 1'b0;

    mult_job_sequencer #(
        .WIDTH       (16),
        .DEPTH       (4),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .mul_rst    (mul_rst),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_err    (out_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Multiplier model: done mdl_lat cycles after the start pulse.
    always @(posedge clk) begin
        mul_done <= 1'b0;
        if (mul_rst) begin
            mdl_busy <= 1'b0;
            mdl_cnt  <= 0;
        end else if (mul_start) begin
            mdl_busy <= 1'b1;
            mdl_cnt  <= 0;
        end else if (mdl_busy && !mdl_hang) begin
            if (mdl_cnt == mdl_lat - 1) begin
                mul_done   <= 1'b1;
                mul_result <= {16'h0, mul_a} * {16'h0, mul_b};
                mdl_busy   <= 1'b0;
            end else begin
                mdl_cnt <= mdl_cnt + 1;
            end
        end
    end

    // Scoreboard: every accepted result must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            out_count++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra got err=%b res=%h required none",
                         out_err, out_result);
            end else begin
                sb_exp = exp_q.pop_front();
                if ({out_err, out_result} !== sb_exp) begin
                    errors++;
                    $display("FAIL scoreboard got err=%b res=%h required err=%b res=%h",
                             out_err, out_result, sb_exp[32], sb_exp[31:0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "bench timed out");
    end

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1;
        out_ready = v;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b,
                        input logic tmo, output int waited);
        logic [31:0] p;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL push_accept a=%h b=%h in_ready=%b required 1",
                     a, b, in_ready);
        end else begin
            p = {16'h0, a} * {16'h0, b};
            exp_q.push_back(tmo ? {1'b1, 32'h0} : {1'b0, p});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (exp_q.size() != 0 || busy) begin
            errors++;
            $display("FAIL %s_drain pending=%0d busy=%b required 0 0",
                     name, exp_q.size(), busy);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, mul_start, out_valid, out_err, busy} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags got %b required 10000",
                     {in_ready, mul_start, out_valid, out_err, busy});
        end
        checks++;
        if ({mul_a, mul_b, out_result} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h required 0",
                     mul_a, mul_b, out_result);
        end
        checks++;
        if (mul_rst !== 1'b1) begin
            errors++;
            $display("FAIL reset_mul_rst got %b required 1", mul_rst);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int   w;
        int   t = 0;
        int   start_cyc = 0;
        logic seen = 1'b0;
        logic unstable = 1'b0;
        mdl_lat = 20;
        push(16'h0003, 16'h0005, 1'b0, w);
        while (!out_valid && t < 200) begin
            @(negedge clk);
            t++;
            if (mul_start) begin
                start_cyc++;
                seen = 1'b1;
            end
            if (seen && (mul_a !== 16'h3 || mul_b !== 16'h5)) begin
                unstable = 1'b1;
            end
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL basic_out_valid got %b required 1", out_valid);
        end
        checks++;
        if (start_cyc != 1) begin
            errors++;
            $display("FAIL basic_start_width got %0d required 1", start_cyc);
        end
        checks++;
        if (unstable) begin
            errors++;
            $display("FAIL basic_operand_hold got unstable required stable");
        end
        checks++;
        if ({out_err, out_result} !== 33'h0_0000_000F) begin
            errors++;
            $display("FAIL basic_result got err=%b res=%h required 0 0000000f",
                     out_err, out_result);
        end
        wait_drain("basic");
    endtask

    task automatic test_zero(input logic [15:0] a, input logic [15:0] b);
        int   w;
        logic v1;
        logic v2;
        logic started = 1'b0;
        push(a, b, 1'b0, w);
        @(negedge clk);
        v1 = out_valid;
        started |= mul_start;
        @(negedge clk);
        v2 = out_valid;
        started |= mul_start;
        checks++;
        if ({v1, v2} !== 2'b01) begin
            errors++;
            $display("FAIL zero_latency got %b%b required 01", v1, v2);
        end
        checks++;
        if (out_result !== 32'h0) begin
            errors++;
            $display("FAIL zero_result got %h required 0", out_result);
        end
        repeat (3) begin
            @(negedge clk);
            started |= mul_start;
        end
        checks++;
        if (started) begin
            errors++;
            $display("FAIL zero_no_start got 1 required 0");
        end
        wait_drain("zero");
    endtask

    task automatic test_burst();
        int w;
        int stalls = 0;
        int base;
        base = out_count;
        mdl_lat = 6;
        for (int i = 0; i < 6; i++) begin
            push(16'(i + 1), 16'(16'h0100 + i), 1'b0, w);
            if (w > 0) stalls++;
        end
        wait_drain("burst");
        checks++;
        if (stalls == 0) begin
            errors++;
            $display("FAIL burst_backpressure got 0 stalls required >0");
        end
        checks++;
        if (out_count - base != 6) begin
            errors++;
            $display("FAIL burst_count got %0d required 6", out_count - base);
        end
    endtask

    task automatic test_stall();
        int   w;
        int   t = 0;
        logic moved = 1'b0;
        logic started = 1'b0;
        logic dropped = 1'b0;
        mdl_lat = 4;
        set_ready(1'b0);
        push(16'h0C00, 16'h1000, 1'b0, w);
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 4; i++) begin
            push(16'(i + 2), 16'h0011, 1'b0, w);
        end
        repeat (50) begin
            @(negedge clk);
            if (out_result !== 32'h00C00000) moved = 1'b1;
            if (mul_start) started = 1'b1;
            if (!out_valid) dropped = 1'b1;
        end
        checks++;
        if (moved || dropped) begin
            errors++;
            $display("FAIL stall_hold got moved=%b dropped=%b required 0 0",
                     moved, dropped);
        end
        checks++;
        if (started) begin
            errors++;
            $display("FAIL stall_no_start got 1 required 0");
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_full got in_ready=%b required 0", in_ready);
        end
        set_ready(1'b1);
        wait_drain("stall");
    endtask

    task automatic test_reset_mid();
        int w;
        int t = 0;
        mdl_lat = 30;
        push(16'h0007, 16'h0009, 1'b0, w);
        push(16'h0004, 16'h0004, 1'b0, w);
        while (!mul_start && t < 50) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, mul_start, out_valid, out_err, busy} !== 5'b10000) begin
            errors++;
            $display("FAIL midrst_flags got %b required 10000",
                     {in_ready, mul_start, out_valid, out_err, busy});
        end
        checks++;
        if ({mul_a, mul_b, out_result} !== 64'h0) begin
            errors++;
            $display("FAIL midrst_data got %h %h %h required 0",
                     mul_a, mul_b, out_result);
        end
        checks++;
        if (mul_rst !== 1'b1) begin
            errors++;
            $display("FAIL midrst_mul_rst got %b required 1", mul_rst);
        end
        exp_q.delete();
        rst = 1'b0;
        push(16'h0002, 16'h0002, 1'b0, w);
        wait_drain("midrst");
    endtask

`ifdef MJS_TIMEOUT_EN
    task automatic test_timeout();
        int w;
        int t = 0;
        mdl_hang = 1'b1;
        push(16'h0005, 16'h0005, 1'b1, w);
        while (!mul_start && t < 20) begin
            @(negedge clk);
            t++;
        end
        t = 0;
        while (!mul_rst && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t != 8) begin
            errors++;
            $display("FAIL timeout_cycles got %0d required 8", t);
        end
        @(negedge clk);
        checks++;
        if ({mul_rst, out_valid, out_err, out_result} !== {3'b011, 32'h0}) begin
            errors++;
            $display("FAIL timeout_out got rst=%b v=%b err=%b res=%h required 0 1 1 0",
                     mul_rst, out_valid, out_err, out_result);
        end
        mdl_hang = 1'b0;
        wait_drain("timeout");
        push(16'h0006, 16'h0007, 1'b0, w);
        wait_drain("after_timeout");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero(16'h0000, 16'h1234);
        test_zero(16'h1234, 16'h0000);
        test_burst();
        test_stall();
        test_reset_mid();
`ifdef MJS_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
